// File: rtl/fns_rx_dec_seq_8_1.sv
// Sequential FNS receive decoder: 9 TSV lines -> 8-bit value, one line per cycle.
// Optional forbidden-transition checker and ftf_err port enabled by FNS_RX_FTF_CHECK_EN.
module fns_rx_dec_seq_8_1 (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] tsv,
    input  logic [8:0] f_flag,
    input  logic       tsv_valid,
    output logic       tsv_ready,
    output logic [7:0] dataout,
    output logic       data_valid,
    input  logic       data_ready,
    output logic [8:0] en_flag,
    output logic       fault_err
`ifdef FNS_RX_FTF_CHECK_EN
    ,
    output logic       ftf_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t     state_q;
    logic [3:0] idx_q;
    logic [7:0] wa_q;
    logic [7:0] wb_q;
    logic [7:0] acc_q;
    logic [8:0] tsv_q;
    logic [8:0] en_q;
    logic [7:0] dataout_q;
    logic       data_valid_q;
    logic       tsv_ready_q;
    logic       fault_q;

    logic [7:0] acc_d;
    logic       line_en_d;
    logic       fault_d;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        line_en_d = en_q[idx_q];
        acc_d     = acc_q;
        if (line_en_d && tsv_q[idx_q]) begin
            acc_d = acc_q + wa_q;
        end
    end

    // More than one faulty line: clearing the lowest set bit still leaves a bit set.
    assign fault_d = |(f_flag & (f_flag - 9'd1));

`ifdef FNS_RX_FTF_CHECK_EN
    logic [7:0] hi_d;
    logic [7:0] lo_d;
    logic [7:0] pair_en_d;
    logic       ftf_d;
    logic       ftf_q;

    // Pair k is lines (k+1, k); even k flags 1->0 upward, odd k flags 0->1 upward.
    always_comb begin
        hi_d      = tsv[8:1];
        lo_d      = tsv[7:0];
        pair_en_d = ~f_flag[8:1] & ~f_flag[7:0];
        ftf_d     = |(((hi_d & ~lo_d & 8'h55) | (~hi_d & lo_d & 8'hAA)) & pair_en_d);
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= 4'd0;
            wa_q         <= 8'd1;
            wb_q         <= 8'd2;
            acc_q        <= 8'd0;
            tsv_q        <= 9'd0;
            en_q         <= 9'd0;
            dataout_q    <= 8'd0;
            data_valid_q <= 1'b0;
            tsv_ready_q  <= 1'b1;
            fault_q      <= 1'b0;
`ifdef FNS_RX_FTF_CHECK_EN
            ftf_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tsv_valid) begin
                        tsv_q       <= tsv;
                        en_q        <= ~f_flag;
                        fault_q     <= fault_d;
`ifdef FNS_RX_FTF_CHECK_EN
                        ftf_q       <= ftf_d;
`endif
                        acc_q       <= 8'd0;
                        idx_q       <= 4'd0;
                        wa_q        <= 8'd1;
                        wb_q        <= 8'd2;
                        tsv_ready_q <= 1'b0;
                        state_q     <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc_q <= acc_d;
                    // Skipped lines leave the Fibonacci weights where they are.
                    if (line_en_d) begin
                        wa_q <= wb_q;
                        wb_q <= wa_q + wb_q;
                    end
                    if (idx_q == 4'd8) begin
                        dataout_q    <= acc_d;
                        data_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (data_ready) begin
                        data_valid_q <= 1'b0;
                        tsv_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    tsv_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign tsv_ready  = tsv_ready_q;
    assign dataout    = dataout_q;
    assign data_valid = data_valid_q;
    assign en_flag    = en_q;
    assign fault_err  = fault_q;
`ifdef FNS_RX_FTF_CHECK_EN
    assign ftf_err    = ftf_q;
`endif

endmodule

// File: doc/fns_rx_dec_seq_8_1.md
# fns_rx_dec_seq_8_1

Sequential receiver-side decoder for the 8-bit, 1-redundant-TSV (9-line) local adaptive Fibonacci-numeral-system (FNS) link. It accepts one 9-bit TSV word and the per-line faulty flags through a valid/ready handshake. It reassigns Fibonacci weights to the healthy lines only, then accumulates the data value serially, one line per cycle. It sits at the receive end of the TSV bundle and is the clocked counterpart of the sender coder, with a handshake toward downstream logic.

## Interface
- No parameters; geometry fixed at 8 data bits, 9 TSV lines.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tsv`  in  9  received TSV word; bit 0 is the first TSV.
- `f_flag`  in  9  faulty flag per TSV line; bit 0 is the first TSV.
- `tsv_valid`  in  1  `tsv` and `f_flag` are valid.
- `tsv_ready`  out  1  decoder can accept a word (IDLE only).
- `dataout`  out  8  decoded data.
- `data_valid`  out  1  `dataout` and the error flags are valid.
- `data_ready`  in  1  downstream accepts `dataout`.
- `en_flag`  out  9  registered `~f_flag` of the captured word.
- `fault_err`  out  1  more than one faulty line in the captured `f_flag`.
- `ftf_err`  out  1  forbidden-transition violation in the captured word; exists only with the configuration macro defined.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: `tsv_ready`=1.
  - On `tsv_valid`=1, capture `tsv` and `f_flag`, register `en_flag`=~`f_flag`, and compute `fault_err`=(popcount(`f_flag`)>1).
  - Clear the accumulator, set index=0, weight pair (wa,wb)=(1,2), and go to ACCUM.
- ACCUM: one line per cycle, index 0..8.
  - If `en_flag`[index]=1: acc += `tsv`[index] ? wa : 0, then (wa,wb) ← (wb, wa+wb).
  - If `en_flag`[index]=0: the line is skipped and the weights do not advance.
  - At index 8, register `dataout`=acc, set `data_valid`=1, and go to DONE.
- Weights on healthy lines are therefore 1,2,3,5,8,13,21,34,55 in ascending line order.
  - Maximum sum is 142, so the 8-bit accumulator never overflows.
  - wa and wb are 8-bit; the final weight advance past 55 is discarded.
- `fault_err`=1 does not stop decoding; `dataout` is still produced by the same rule.
- DONE: `data_valid`=1, and `dataout` and the flags are held stable.
  - On `data_ready`=1, go to IDLE and clear `data_valid` on that edge.
- `tsv_valid` is ignored outside IDLE.
- `tsv` and `f_flag` may change freely after capture.
- `reset` in any state (including mid-ACCUM or DONE): state=IDLE and all outputs 0 on the next edge, except `tsv_ready`, which is 1 in IDLE. The partial accumulation is discarded.

## Timing
- Reset values: `tsv_ready`=1, `data_valid`=0, `dataout`=0, `en_flag`=0, `fault_err`=0, `ftf_err`=0.
- Edge E0 accepts the word; edges E1..E9 process lines 0..8.
- `data_valid` is high after E9, giving 9 cycles of latency from the acceptance edge.
- If `data_ready` is high at E10, `tsv_ready` is high after E10, and the next word can be accepted at E11.
- Minimum spacing between accepted words is 11 cycles; there is no pipelining.
- `data_ready` may be held high permanently; DONE then lasts exactly one cycle.

## Configuration
- `FNS_RX_FTF_CHECK_EN` defined: the `ftf_err` port and checker are present.
  - Evaluated on the captured word at E0 and registered.
  - For m=1..4, a violation is (`tsv`[2m]=0 ∧ `tsv`[2m-1]=1 ∧ `en`[2m] ∧ `en`[2m-1]) ∨ (`tsv`[2m-1]=1 ∧ `tsv`[2m-2]=0 ∧ `en`[2m-1] ∧ `en`[2m-2]).
  - `ftf_err` is the OR over all m, held until leaving DONE.
- Not defined: no `ftf_err` port and no checker logic; all other behaviour is identical.

## Test plan
- Reset, then `f_flag`=0, `tsv`=9'b000010101 → after 9 cycles `dataout`=12, `en_flag`=9'h1FF, `fault_err`=0, `ftf_err`=0.
- `f_flag`=9'b000000001, `tsv`=9'b000000110 → `dataout`=3 (line 1 weight 1, line 2 weight 2), `ftf_err`=0 because line 0 is disabled.
- `f_flag`=0, `tsv`=9'b111111111 → `dataout`=142; `f_flag`=0, `tsv`=9'b000000010 → `dataout`=2, `ftf_err`=1 with the macro defined.
- `f_flag`=9'b000010010 → `fault_err`=1, `en_flag`=9'b111101101, and `dataout` is decoded with weights assigned to the 7 healthy lines.
- Back-pressure: hold `data_ready`=0 for 5 cycles in DONE while driving a new `tsv_valid` word → `dataout` stable, `tsv_ready`=0, and the new word is not captured; after release, the next word is accepted one cycle later.
- Assert `reset` at ACCUM index 4 → next cycle IDLE, `tsv_ready`=1, `data_valid`=0, `dataout`=0; a fresh word then decodes correctly.
